a2d_rr_intf: RTL and testbench
==============================

A2D_RR_INTF -- requirements
Module: a2d_rr_intf

Interface
REQ-001 SHALL have parameter CH0, default 3'd0: A2D channel code for slot 0.
REQ-002 SHALL have parameter CH1, default 3'd1: A2D channel code for slot 1.
REQ-003 SHALL have parameter CH2, default 3'd2: A2D channel code for slot 2.
REQ-004 SHALL have parameter CH3, default 3'd3: A2D channel code for slot 3.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all flops sample on posedge clk.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port strt_cnv, input, 1 bit: a one-cycle pulse that starts one round of 4 conversions.
REQ-008 SHALL have port wrt, output, 1 bit: one-cycle pulse that launches a 16-bit SPI transaction.
REQ-009 SHALL have port cmd, output, 16 bits: command word presented with wrt.
REQ-010 SHALL have port done, input, 1 bit: SPI transaction complete; held high until the next wrt.
REQ-011 SHALL have port rd_data, input, 16 bits: SPI read word, valid while done=1.
REQ-012 SHALL have ports res0, res1, res2 and res3, outputs, 12 bits each: latest conversion result per slot.
REQ-013 SHALL have port cnv_cmplt, output, 1 bit: one-cycle pulse at the end of a round.
REQ-014 SHALL have port busy, output, 1 bit: high from strt_cnv acceptance until cnv_cmplt.

Function
REQ-015 SHALL run the FSM states IDLE, TX1, GAP, TX2 and STORE.
REQ-016 In IDLE with strt_cnv=1: SHALL set slot counter slot=0, pulse wrt and go to TX1.
REQ-017 cmd SHALL equal {2'b00, CHn[2:0], 11'h000} for the current slot n, driven combinationally from slot.
REQ-018 cmd SHALL hold that value in every state.
REQ-019 TX1: SHALL wait for done=1, then go to GAP with no wrt.
REQ-020 done SHALL be evaluated only from the cycle after the wrt pulse.
REQ-021 GAP: SHALL last exactly 1 cycle, then pulse wrt and go to TX2.
REQ-022 In the second transaction, MOSI content is don't-care and cmd SHALL repeat the same word.
REQ-023 TX2: on done=1, SHALL go to STORE.
REQ-024 STORE (1 cycle): SHALL load rd_data[11:0] into res<slot>; rd_data[15:12] SHALL be discarded.
REQ-025 STORE with slot<3: SHALL increment slot, pulse wrt and go to TX1.
REQ-026 STORE with slot==3: SHALL pulse cnv_cmplt, clear busy and go to IDLE; slot SHALL wrap to 0.
REQ-027 wrt SHALL be registered, glitch-free, and never high for two consecutive cycles.
REQ-028 Only the res register of the current slot SHALL change, and only in STORE; the other res registers SHALL hold.
REQ-029 strt_cnv while busy=1 SHALL be ignored: no restart and no queuing.
REQ-030 strt_cnv in the same cycle as the STORE of slot 3 SHALL be ignored; a new round needs strt_cnv in IDLE.
REQ-031 The block SHALL have no timeout: if done never rises, the FSM stays in TX1 or TX2.
REQ-032 Minimum round latency SHALL be 4 x (2 SPI transactions + GAP + STORE + wrt cycles) from strt_cnv to cnv_cmplt.
REQ-033 busy SHALL fall in the same cycle cnv_cmplt is high.

Reset
REQ-034 rst_n low SHALL take effect immediately: state=IDLE, slot=0, wrt=0, cnv_cmplt=0, busy=0, res0..res3=12'h000.
REQ-035 Reset mid-round SHALL abort the round without storing partial results.
REQ-036 After release, the block SHALL wait for a new strt_cnv.

Verification
REQ-037 Reset: assert rst_n=0 mid-TX2 -> wrt=0, busy=0, res0..3=0 in the same cycle; no activity until strt_cnv.
REQ-038 Single round with an SPI slave model returning 16'hF000|(0x100*slot+0x23) -> res0=12'h023, res1=12'h123, res2=12'h223, res3=12'h323; upper nibble ignored; cnv_cmplt pulses once.
REQ-039 Command check: CH0..CH3 = 3'd7,3'd4,3'd0,3'd2 -> wrt count=8, cmds in order 16'h3800,16'h3800,16'h2000,16'h2000,16'h0000,16'h0000,16'h1000,16'h1000.
REQ-040 strt_cnv pulsed during the slot-1 TX1 -> still exactly 8 wrt pulses and 1 cnv_cmplt.
REQ-041 Back-to-back: strt_cnv 1 cycle after cnv_cmplt -> second round starts; res updated with new model values; no stale res.
REQ-042 Stalled slave: done held 0 for 5000 cycles in TX1 -> no wrt pulses, busy=1; release done -> round completes normally.

Source files
------------

// File: rtl/a2d_rr_intf.sv
// a2d_rr_intf: round-robin A2D sequencer; each slot issues two SPI transactions
// (command, then readback) and stores the 12-bit result of the second one.
module a2d_rr_intf #(
    parameter logic [2:0] CH0 = 3'd0,
    parameter logic [2:0] CH1 = 3'd1,
    parameter logic [2:0] CH2 = 3'd2,
    parameter logic [2:0] CH3 = 3'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] res0,
    output logic [11:0] res1,
    output logic [11:0] res2,
    output logic [11:0] res3,
    output logic        cnv_cmplt,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, STORE} state_t;
    state_t      state_q;
    logic [1:0]  slot_q;
    logic        wrt_q;
    logic        cmplt_q;
    logic        busy_q;
    logic [11:0] res_q [4];
    logic [2:0]  ch;
    assign ch = slot_q == 2'd0 ? CH0 : slot_q == 2'd1 ? CH1 : slot_q == 2'd2 ? CH2 : CH3;
    assign cmd = {2'b00, ch, 11'h000};
    assign wrt = wrt_q;
    assign cnv_cmplt = cmplt_q;
    assign busy = busy_q;
    assign res0 = res_q[0];
    assign res1 = res_q[1];
    assign res2 = res_q[2];
    assign res3 = res_q[3];
    // done is still high from the previous transaction while wrt is out, so it is
    // only trusted once the wrt pulse has passed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            slot_q   <= 2'd0;
            wrt_q    <= 1'b0;
            cmplt_q  <= 1'b0;
            busy_q   <= 1'b0;
            res_q[0] <= 12'h000;
            res_q[1] <= 12'h000;
            res_q[2] <= 12'h000;
            res_q[3] <= 12'h000;
        end else begin
            wrt_q   <= 1'b0;
            cmplt_q <= 1'b0;
            case (state_q)
                IDLE: if (strt_cnv) begin
                    slot_q  <= 2'd0;
                    wrt_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= TX1;
                end
                TX1: if (done && !wrt_q) state_q <= GAP;
                GAP: begin
                    wrt_q   <= 1'b1;
                    state_q <= TX2;
                end
                TX2: if (done && !wrt_q) state_q <= STORE;
                STORE: begin
                    res_q[slot_q] <= rd_data[11:0];
                    if (slot_q != 2'd3) begin
                        slot_q  <= slot_q + 2'd1;
                        wrt_q   <= 1'b1;
                        state_q <= TX1;
                    end else begin
                        slot_q  <= 2'd0;
                        cmplt_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_rr_intf.sv
// tb_a2d_rr_intf: directed rounds against an SPI slave model with random latency
// and random read words; results and command order come from a per-round model.
module tb_a2d_rr_intf;
    localparam logic [2:0] C0 = 3'd7;
    localparam logic [2:0] C1 = 3'd4;
    localparam logic [2:0] C2 = 3'd0;
    localparam logic [2:0] C3 = 3'd2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cnv = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, cnv_cmplt, busy;
    logic [15:0] cmd;
    logic [11:0] res0, res1, res2, res3;
    logic [2:0]  ch [4] = '{C0, C1, C2, C3};
    logic [15:0] vals [4];
    logic [15:0] cmds [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wrt_cnt = 0;
    int          cmplt_cnt = 0;
    int          cnt = 0;
    int          cur = 0;
    bit          stall = 1'b0;
    logic        prev_wrt = 1'b0;
    logic        cmplt_busy = 1'b1;

    always #5 clk = ~clk;

    a2d_rr_intf #(.CH0(C0), .CH1(C1), .CH2(C2), .CH3(C3)) dut (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .wrt(wrt), .cmd(cmd),
        .done(done), .rd_data(rd_data), .res0(res0), .res1(res1), .res2(res2),
        .res3(res3), .cnv_cmplt(cnv_cmplt), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int slot_of(input logic [2:0] c);
        for (int s = 0; s < 4; s++) if (ch[s] == c) return s;
        return 0;
    endfunction

    // SPI slave + bus monitor, sampled just after each rising edge
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            done = 1'b0;
            cnt = 0;
            prev_wrt = 1'b0;
        end else begin
            if (wrt) begin
                chk("wrt_single", {31'd0, prev_wrt}, 0);
                wrt_cnt++;
                cmds.push_back(cmd);
                cur = slot_of(cmd[13:11]);
                done = 1'b0;
                cnt = int'($urandom_range(1, 6));
            end else if (cnt > 0 && !stall) begin
                cnt--;
                if (cnt == 0) begin
                    rd_data = vals[cur];
                    done = 1'b1;
                end
            end
            if (cnv_cmplt) begin
                cmplt_cnt++;
                cmplt_busy = busy;
            end
            prev_wrt = wrt;
        end
    end

    task automatic rand_vals();
        for (int s = 0; s < 4; s++) vals[s] = 16'($urandom);
    endtask

    task automatic run_round(input int extra_at, input bit stall_first);
        int n;
        wrt_cnt = 0;
        cmplt_cnt = 0;
        cmds.delete();
        stall = stall_first;
        @(negedge clk) strt_cnv = 1'b1;
        @(negedge clk) strt_cnv = 1'b0;
        chk("busy_start", {31'd0, busy}, 1);
        if (stall_first) begin
            repeat (5000) @(negedge clk);
            chk("stall_wrt_cnt", wrt_cnt, 1);
            chk("stall_busy", {31'd0, busy}, 1);
            stall = 1'b0;
        end
        if (extra_at > 0) begin
            n = 0;
            while (wrt_cnt < extra_at && n < 500) begin
                @(negedge clk);
                n++;
            end
            strt_cnv = 1'b1;
            @(negedge clk) strt_cnv = 1'b0;
        end
        n = 0;
        while (!cnv_cmplt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("round_done", {31'd0, cnv_cmplt}, 1);
        chk("busy_at_cmplt", {31'd0, busy}, 0);
        chk("cmplt_busy_mon", {31'd0, cmplt_busy}, 0);
        chk("cmplt_cnt", cmplt_cnt, 1);
        chk("wrt_cnt", wrt_cnt, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("cmd[%0d]", i), i < cmds.size() ? {16'd0, cmds[i]} : 32'hxxxx,
                32'(ch[i / 2]) * 32'h800);
        chk("res0", {20'd0, res0}, 32'(vals[0] % 16'h1000));
        chk("res1", {20'd0, res1}, 32'(vals[1] % 16'h1000));
        chk("res2", {20'd0, res2}, 32'(vals[2] % 16'h1000));
        chk("res3", {20'd0, res3}, 32'(vals[3] % 16'h1000));
    endtask

    initial begin
        int n;
        for (int s = 0; s < 4; s++) vals[s] = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_wrt", {31'd0, wrt}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_cmplt", {31'd0, cnv_cmplt}, 0);
        chk("rst_res", {res0, res1, res2[11:4]}, 0);
        chk("rst_res3", {20'd0, res3}, 0);
        chk("rst_cmd", {16'd0, cmd}, 32'h3800);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_wrt", {31'd0, wrt}, 0);
        // fixed slave words: upper nibble set, must be dropped
        for (int s = 0; s < 4; s++) vals[s] = 16'hF000 | (16'h100 * 16'(s) + 16'h23);
        run_round(0, 1'b0);
        chk("spec_res0", {20'd0, res0}, 32'h023);
        chk("spec_res1", {20'd0, res1}, 32'h123);
        chk("spec_res2", {20'd0, res2}, 32'h223);
        chk("spec_res3", {20'd0, res3}, 32'h323);
        chk("spec_cmd0", {16'd0, cmds[0]}, 32'h3800);
        chk("spec_cmd3", {16'd0, cmds[3]}, 32'h2000);
        chk("spec_cmd5", {16'd0, cmds[5]}, 32'h0000);
        chk("spec_cmd7", {16'd0, cmds[7]}, 32'h1000);
        // strt_cnv while busy in slot-1 TX1 must be ignored
        rand_vals();
        run_round(3, 1'b0);
        repeat (3) @(negedge clk);
        chk("no_restart_busy", {31'd0, busy}, 0);
        chk("no_restart_wrt", wrt_cnt, 8);
        // back-to-back rounds, each one started right after the previous cnv_cmplt
        for (int r = 0; r < 4; r++) begin
            rand_vals();
            run_round(0, 1'b0);
        end
        rand_vals();
        run_round(0, 1'b1);
        // reset while the slot-0 second transaction is in flight
        rand_vals();
        wrt_cnt = 0;
        @(negedge clk) strt_cnv = 1'b1;
        @(negedge clk) strt_cnv = 1'b0;
        n = 0;
        while (wrt_cnt < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_tx2", wrt_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wrt", {31'd0, wrt}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_res", {res0, res1, res2[11:4]}, 0);
        chk("mid_rst_res3", {20'd0, res3}, 0);
        @(negedge clk) rst_n = 1'b1;
        wrt_cnt = 0;
        repeat (30) @(negedge clk);
        chk("post_rst_wrt", wrt_cnt, 0);
        chk("post_rst_busy", {31'd0, busy}, 0);
        chk("post_rst_res0", {20'd0, res0}, 0);
        rand_vals();
        run_round(0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
